uart_key_decoder: RTL

//  Converts received UART bytes (rx_data/rx_done) into button pulses, latched mode/display

---
 rtl/uart_key_decoder.sv | 99 +++++++++
 1 files changed

// File: rtl/uart_key_decoder.sv
// uart_key_decoder: maps UART key bytes to stretched button pulses, latched toggles and an ESC reset hold.
// Optional UART_ECHO_EN adds a key echo path with a 1-entry holding register.
module uart_key_decoder #(
  parameter int PULSE_CYC = 100_000,
  parameter int ESC_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] btn_out,
  output logic       esc_rst,
  output logic       busy
`ifdef UART_ECHO_EN
  ,
  output logic       tx_start,
  output logic [7:0] tx_din,
  input  logic       tx_busy
`endif
);
  localparam int MAXC = PULSE_CYC > ESC_CYC ? PULSE_CYC : ESC_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] P_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] E_LD = CW'(ESC_CYC - 1);
  typedef enum logic [1:0] {IDLE, PULSE, ESC_HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0] btn_nx, lc;
  logic [3:0] key_btn;
  logic key_m, key_s, key_esc;
  // Setting bit 5 folds upper-case letters onto lower case; ESC is unaffected.
  assign lc = rx_data | 8'h20;
  assign key_btn = rx_done ? {lc == 8'h6C, lc == 8'h72, lc == 8'h75, lc == 8'h64} : 4'b0;
  assign key_m = rx_done && lc == 8'h6D;
  assign key_s = rx_done && lc == 8'h73;
  assign key_esc = rx_done && rx_data == 8'h1B;
  assign esc_rst = state == ESC_HOLD;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      btn_out <= 8'h00;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      btn_out <= btn_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt != '0 ? cnt - 1'b1 : cnt;
    btn_nx = btn_out;
    if (state == ESC_HOLD) begin
      btn_nx = 8'h00;
      state_nx = cnt == '0 ? IDLE : ESC_HOLD;
    end else if (key_esc) begin
      state_nx = ESC_HOLD;
      cnt_nx = E_LD;
      btn_nx = 8'h00;
    end else begin
      btn_nx[1:0] = btn_out[1:0] ^ {key_m, key_s};
      if (state == IDLE && |key_btn) begin
        state_nx = PULSE;
        cnt_nx = P_LD;
        btn_nx[5:2] = key_btn;
      end else if (state == PULSE && cnt == '0) begin
        state_nx = IDLE;
        btn_nx[5:2] = 4'b0;
      end
    end
  end
`ifdef UART_ECHO_EN
  logic [7:0] hold;
  logic hold_v, acc;
  // Button keys arriving mid-pulse are dropped, so they are not echoed either.
  assign acc = state != ESC_HOLD && (key_esc || key_m || key_s || (state == IDLE && |key_btn));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_start <= 1'b0;
      tx_din <= 8'h00;
      hold <= 8'h00;
      hold_v <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (acc && !tx_busy) begin
        tx_start <= 1'b1;
        tx_din <= rx_data;
        hold_v <= 1'b0;
      end else if (acc) begin
        hold <= rx_data;
        hold_v <= 1'b1;
      end else if (hold_v && !tx_busy) begin
        tx_start <= 1'b1;
        tx_din <= hold;
        hold_v <= 1'b0;
      end
    end
`endif
endmodule
